// File: rtl/io_port_unit_if.sv
// CPU/device-facing bus of io_port_unit: input channels, CPU IN/OUT strobes
// and the output stream handshake.
interface io_port_unit_if #(
  parameter int DATA_W = 16,
  parameter int IN_CH  = 2,
  parameter int SEL_W  = 1,
  parameter int CNT_W  = 3
);
  logic [IN_CH*DATA_W-1:0] in_data;
  logic [IN_CH-1:0]        in_valid;
  logic [IN_CH-1:0]        in_ready;
  logic [SEL_W-1:0]        cpu_in_sel;
  logic                    cpu_rd;
  logic [DATA_W-1:0]       cpu_rd_data;
  logic                    cpu_in_avail;
  logic                    cpu_wr;
  logic [DATA_W-1:0]       cpu_wr_data;
  logic                    cpu_stall;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [CNT_W-1:0]        out_count;

  modport master (
    output in_data, in_valid, cpu_in_sel, cpu_rd, cpu_wr, cpu_wr_data, out_ready,
    input  in_ready, cpu_rd_data, cpu_in_avail, cpu_stall, out_data, out_valid, out_count
  );

  modport slave (
    input  in_data, in_valid, cpu_in_sel, cpu_rd, cpu_wr, cpu_wr_data, out_ready,
    output in_ready, cpu_rd_data, cpu_in_avail, cpu_stall, out_data, out_valid, out_count
  );
endinterface

// File: rtl/io_port_unit.sv
// Buffered CPU I/O: IN_CH one-word input holding registers and an
// OUT_DEPTH-word output FIFO that stalls the CPU when full.
module io_port_unit #(
  parameter int DATA_W    = 16,
  parameter int IN_CH     = 2,
  parameter int SEL_W     = 1,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input logic          clk,
  input logic          rst,
  io_port_unit_if.slave bus
);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  logic [DATA_W-1:0] hold [IN_CH];
  logic [IN_CH-1:0]  full;
  logic [IN_CH-1:0]  rd_hit;

  always_comb begin
    rd_hit = '0;
    for (int c = 0; c < IN_CH; c++) begin
      rd_hit[c] = bus.cpu_rd && (bus.cpu_in_sel == SEL_W'(c));
    end
  end

  // in_ready gates capture, so capture and consume never meet on one channel.
  for (genvar c = 0; c < IN_CH; c++) begin : g_ch
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold[c] <= '0;
        full[c] <= 1'b0;
      end else if (bus.in_valid[c] && !full[c]) begin
        hold[c] <= bus.in_data[c*DATA_W +: DATA_W];
        full[c] <= 1'b1;
      end else if (rd_hit[c] && full[c]) begin
        full[c] <= 1'b0;
      end
    end
  end

  assign bus.in_ready = ~full;

  // Out-of-range selects match no channel and read back as zero.
  always_comb begin
    bus.cpu_rd_data  = '0;
    bus.cpu_in_avail = 1'b0;
    for (int c = 0; c < IN_CH; c++) begin
      if (bus.cpu_in_sel == SEL_W'(c)) begin
        bus.cpu_rd_data  = hold[c];
        bus.cpu_in_avail = full[c];
      end
    end
  end

  logic [DATA_W-1:0] mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign fifo_full  = (count == CNT_W'(OUT_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = bus.cpu_wr && !fifo_full;
  assign pop        = !fifo_empty && bus.out_ready;

  // No full-bypass: a pop in the same cycle does not release the stall.
  assign bus.cpu_stall = bus.cpu_wr && fifo_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= bus.cpu_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign bus.out_data  = mem[rd_ptr];
  assign bus.out_valid = !fifo_empty;
  assign bus.out_count = count;
endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit with hand-computed expectations.
module tb_io_port_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  io_port_unit_if #(.DATA_W(16), .IN_CH(2), .SEL_W(1), .CNT_W(3)) bus ();

  io_port_unit #(.DATA_W(16), .IN_CH(2), .SEL_W(1), .OUT_DEPTH(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_data     = '0;
    bus.in_valid    = '0;
    bus.cpu_in_sel  = '0;
    bus.cpu_rd      = 1'b0;
    bus.cpu_wr      = 1'b0;
    bus.cpu_wr_data = '0;
    bus.out_ready   = 1'b0;

    #3;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h3);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_count", 32'(bus.out_count), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_stall", 32'(bus.cpu_stall), 32'h0);
    #3 rst = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'h3);
    chk("post_rst_count", 32'(bus.out_count), 32'h0);

    // channel 0 capture and consume
    bus.in_data[15:0] = 16'd20;
    bus.in_valid      = 2'b01;
    tick();
    bus.in_valid   = 2'b00;
    bus.cpu_in_sel = 1'b0;
    #1;
    chk("ch0_rd_data", 32'(bus.cpu_rd_data), 32'd20);
    chk("ch0_avail", 32'(bus.cpu_in_avail), 32'h1);
    chk("ch0_in_ready", 32'(bus.in_ready[0]), 32'h0);
    bus.cpu_rd = 1'b1;
    tick();
    bus.cpu_rd = 1'b0;
    #1;
    chk("ch0_consumed_avail", 32'(bus.cpu_in_avail), 32'h0);
    chk("ch0_consumed_ready", 32'(bus.in_ready[0]), 32'h1);
    chk("ch0_stale_data", 32'(bus.cpu_rd_data), 32'd20);

    // channel 1 independence and back-pressure
    bus.in_data[31:16] = 16'h1234;
    bus.in_valid       = 2'b10;
    tick();
    bus.in_valid = 2'b00;
    #1;
    chk("ch0_empty_while_ch1", 32'(bus.cpu_in_avail), 32'h0);
    bus.cpu_in_sel = 1'b1;
    #1;
    chk("ch1_rd_data", 32'(bus.cpu_rd_data), 32'h1234);
    chk("ch1_avail", 32'(bus.cpu_in_avail), 32'h1);
    bus.in_data[31:16] = 16'h5678;
    bus.in_valid       = 2'b10;
    tick();
    chk("ch1_blocked_data", 32'(bus.cpu_rd_data), 32'h1234);
    chk("ch1_blocked_ready", 32'(bus.in_ready[1]), 32'h0);
    bus.cpu_rd = 1'b1;
    tick();
    bus.cpu_rd = 1'b0;
    #1;
    chk("ch1_after_consume_avail", 32'(bus.cpu_in_avail), 32'h0);
    chk("ch1_after_consume_data", 32'(bus.cpu_rd_data), 32'h1234);
    tick();
    bus.in_valid = 2'b00;
    #1;
    chk("ch1_second_data", 32'(bus.cpu_rd_data), 32'h5678);
    chk("ch1_second_avail", 32'(bus.cpu_in_avail), 32'h1);
    bus.cpu_rd = 1'b1;
    tick();
    bus.cpu_rd = 1'b0;

    // fill FIFO, stall, then drain
    bus.out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      bus.cpu_wr      = 1'b1;
      bus.cpu_wr_data = 16'(v);
      tick();
    end
    bus.cpu_wr = 1'b0;
    #1;
    chk("fill_count", 32'(bus.out_count), 32'd4);
    chk("fill_head", 32'(bus.out_data), 32'd1);
    chk("fill_no_stall_idle", 32'(bus.cpu_stall), 32'h0);
    bus.cpu_wr      = 1'b1;
    bus.cpu_wr_data = 16'd5;
    #1;
    chk("full_stall", 32'(bus.cpu_stall), 32'h1);
    tick();
    chk("full_hold_count", 32'(bus.out_count), 32'd4);
    chk("full_hold_head", 32'(bus.out_data), 32'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("no_full_bypass", 32'(bus.cpu_stall), 32'h1);
    tick();
    chk("drain_head2", 32'(bus.out_data), 32'd2);
    chk("drain_count3", 32'(bus.out_count), 32'd3);
    chk("stall_released", 32'(bus.cpu_stall), 32'h0);
    tick();
    bus.cpu_wr = 1'b0;
    #1;
    chk("drain_head3", 32'(bus.out_data), 32'd3);
    chk("drain_count_pp", 32'(bus.out_count), 32'd3);
    tick();
    chk("drain_head4", 32'(bus.out_data), 32'd4);
    tick();
    chk("drain_head5", 32'(bus.out_data), 32'd5);
    chk("drain_count1", 32'(bus.out_count), 32'd1);
    tick();
    chk("drain_empty_valid", 32'(bus.out_valid), 32'h0);
    chk("drain_empty_count", 32'(bus.out_count), 32'd0);

    // streaming with wrap
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cpu_wr      = 1'b1;
      bus.cpu_wr_data = 16'(10 + i);
      tick();
      chk("stream_count", 32'(bus.out_count), 32'd1);
      chk("stream_head", 32'(bus.out_data), 32'(10 + i));
    end
    bus.cpu_wr = 1'b0;
    tick();
    chk("stream_end_count", 32'(bus.out_count), 32'd0);

    // simultaneous push/pop at count 2
    bus.out_ready = 1'b0;
    bus.cpu_wr    = 1'b1;
    bus.cpu_wr_data = 16'd30;
    tick();
    bus.cpu_wr_data = 16'd31;
    tick();
    bus.cpu_wr = 1'b0;
    #1;
    chk("pp_pre_count", 32'(bus.out_count), 32'd2);
    chk("pp_pre_head", 32'(bus.out_data), 32'd30);
    bus.cpu_wr      = 1'b1;
    bus.cpu_wr_data = 16'd32;
    bus.out_ready   = 1'b1;
    tick();
    bus.cpu_wr    = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("pp_count", 32'(bus.out_count), 32'd2);
    chk("pp_head", 32'(bus.out_data), 32'd31);
    tick();
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("pp_drained", 32'(bus.out_count), 32'd0);

    // asynchronous reset mid-transfer
    bus.cpu_wr = 1'b1;
    for (int v = 40; v < 43; v++) begin
      bus.cpu_wr_data = 16'(v);
      tick();
    end
    bus.cpu_wr        = 1'b0;
    bus.in_data[15:0] = 16'h0099;
    bus.in_valid      = 2'b01;
    tick();
    bus.in_valid   = 2'b00;
    bus.cpu_in_sel = 1'b0;
    #1;
    chk("pre_rst_count", 32'(bus.out_count), 32'd3);
    chk("pre_rst_ch0", 32'(bus.cpu_rd_data), 32'h99);
    rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus.out_count), 32'd0);
    chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("async_rst_out_data", 32'(bus.out_data), 32'h0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'h3);
    chk("async_rst_hold", 32'(bus.cpu_rd_data), 32'h0);
    #2 rst = 1'b1;
    tick();
    chk("after_rst_count", 32'(bus.out_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/io_port_unit.md
Name: io_port_unit

Overview:
- Parametrised successor to the CPU's single fixed 16-bit in_port/out_port pair.
- Provides IN_CH buffered input channels, each with a valid/ready handshake and a one-word holding register.
- Provides one output stream backed by an OUT_DEPTH-word FIFO with valid/ready handshake.
- Sits between the CPU execute/memory stage (IN/OUT instructions) and external devices. Issues a stall when an OUT cannot be accepted.

Parameters:
- DATA_W, 16: port word width.
- IN_CH, 2: number of input channels (1..16).
- SEL_W, 1: channel select width; must satisfy 2**SEL_W >= IN_CH.
- OUT_DEPTH, 4: output FIFO depth in words; power of 2, >= 2.
- CNT_W, 3: FIFO occupancy width, log2(OUT_DEPTH)+1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  IN_CH*DATA_W  external input words; channel c occupies bits [c*DATA_W +: DATA_W].
- in_valid  in  IN_CH  per-channel external word valid.
- in_ready  out  IN_CH  per-channel holding register empty.
- cpu_in_sel  in  SEL_W  channel addressed by an IN instruction.
- cpu_rd  in  1  IN instruction consumes the selected channel this cycle.
- cpu_rd_data  out  DATA_W  holding register of the selected channel (combinational).
- cpu_in_avail  out  1  selected channel holds an unread word.
- cpu_wr  in  1  OUT instruction pushes cpu_wr_data.
- cpu_wr_data  in  DATA_W  word to output.
- cpu_stall  out  1  cpu_wr asserted while the FIFO is full.
- out_data  out  DATA_W  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  external sink accepts the head word.
- out_count  out  CNT_W  FIFO occupancy, 0..OUT_DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - all holding registers are 0; all full flags clear, so in_ready is all ones.
  - FIFO read/write pointers and count are 0: out_valid=0, out_count=0, out_data=0.
  - cpu_stall=0 while cpu_wr=0.
  - Reset asserted mid-transfer discards all buffered words, with no partial state kept.
- Input channel c (identical logic per channel):
  - in_ready[c] = ~full[c].
  - Capture: in_valid[c] & in_ready[c] at a clock edge loads hold[c] and sets full[c]. The word is visible on cpu_rd_data the next cycle.
  - Consume: cpu_rd with cpu_in_sel==c and full[c] clears full[c] at the edge. hold[c] retains its value.
  - cpu_rd on an empty channel has no state effect. cpu_rd_data still shows the stale hold[c] and cpu_in_avail=0. The CPU uses cpu_in_avail to distinguish stale data.
  - Capture and consume on the same channel in the same cycle cannot occur, because in_ready is low while full.
  - cpu_in_sel >= IN_CH: cpu_rd_data=0, cpu_in_avail=0, and reads are ignored.
  - Channels are independent; captures on several channels in one cycle are all taken.
- Output FIFO:
  - push = cpu_wr & (count < OUT_DEPTH).
  - pop = out_valid & out_ready.
  - cpu_stall = cpu_wr & (count == OUT_DEPTH), combinational. This holds even if pop is asserted the same cycle, so there is no full-bypass.
  - The CPU must hold cpu_wr/cpu_wr_data stable while stalled; no word is dropped.
  - out_data = mem[rd_ptr], valid when out_valid=1. It must stay stable while out_valid & ~out_ready.
  - Push and pop in the same cycle (not full, not empty): count is unchanged and both pointers advance.
  - Push to an empty FIFO: the word appears on out_data with out_valid=1 the next cycle (latency 1). There is no write-to-output bypass.
  - Pointers are log2(OUT_DEPTH) bits and wrap modulo OUT_DEPTH.
  - count increments on push-only, decrements on pop-only, otherwise holds.
  - Pop from an empty FIFO cannot occur, because out_valid=0.
- Widths: all data paths are DATA_W; no arithmetic on data, so no sign or extension rules.

Test Plan:
- Reset, then rst low for 6 units and high again: in_ready=all ones, out_valid=0, out_count=0, cpu_stall=0. Pulse rst low mid-FIFO (count=3): count returns to 0 asynchronously.
- in_data ch0=20, in_valid[0]=1 for one cycle, then cpu_in_sel=0, cpu_rd=1:
  - after the capture edge: cpu_rd_data=20, cpu_in_avail=1, in_ready[0]=0.
  - after the consume edge: cpu_in_avail=0, in_ready[0]=1.
- ch1 loaded with 0x1234 while ch0 is empty, cpu_in_sel=0: cpu_in_avail=0. Switching cpu_in_sel=1 gives cpu_rd_data=0x1234 and cpu_in_avail=1. A second in_valid[1] with 0x5678 is not captured until ch1 is consumed.
- out_ready=0, push 1,2,3,4, then a fifth push with cpu_wr=1 and data 5:
  - out_count=4; cpu_stall=1 on the fifth push.
  - raising out_ready pops 1, the stalled 5 is accepted the next cycle, and the drain order is 1,2,3,4,5.
- Steady state with out_ready=1, a push every cycle of values 10..17: out_count stays at 1, out_data follows one cycle behind, and the pointers wrap with no loss or duplication.
- Push and pop in the same cycle at count=2: out_count stays 2 and the head advances to the next word.
